move_cmd_gen: RTL and testbench
===============================

MOVE_CMD_GEN -- requirements
Module: move_cmd_gen

Interface
REQ-001 Parameter DEB_CYCLES, default 16'd50000, meaning: consecutive stable cycles needed to accept a button level.
REQ-002 Parameter DAS_CYCLES, default 24'd10000000, meaning: hold time before auto-repeat starts.
REQ-003 Parameter ARR_CYCLES, default 24'd2500000, meaning: auto-repeat period.
REQ-004 clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 btn_l, btn_r, btn_c  input  1 each  raw asynchronous board buttons for left, right and fall.
REQ-007 key_left, key_right, key_fall  input  1 each  keyboard hold levels, already synchronous to clk.
REQ-008 cmd_valid  output  1  a command is buffered.
REQ-009 cmd  output  2  command code: 2'b01 left, 2'b10 right, 2'b11 fall, 2'b00 none.
REQ-010 cmd_ack  input  1  consumer accepts the command.
REQ-011 cmd_drop  output  1  sticky flag: an event was lost.

Function
REQ-012 Each btn_* input SHALL pass through a 2-flop synchronizer, then a debouncer; the debounced level changes only after DEB_CYCLES consecutive equal samples.
REQ-013 Combined level per direction SHALL be debounced button OR key level, registered once.
REQ-014 A 0->1 transition of a registered combined level SHALL produce a one-cycle press event.
REQ-015 The command buffer SHALL hold one entry; when empty, or acked in the same cycle, it loads the highest-priority event on the next edge.
REQ-016 Event priority SHALL be fall > left > right; lower-priority simultaneous events are discarded and set cmd_drop.
REQ-017 An event arriving while cmd_valid=1 and cmd_ack=0 SHALL be discarded and set cmd_drop.
REQ-018 cmd_ack while cmd_valid=1 SHALL clear cmd_valid and set cmd to 2'b00 on the same edge, unless a new event loads on that edge.
REQ-019 cmd_ack while cmd_valid=0 SHALL be ignored.
REQ-020 Latency: a key level first sampled high at edge n SHALL produce cmd_valid=1 after edge n+2.
REQ-021 The auto-repeat FSM SHALL have states IDLE, DELAY and REPEAT, with a 24-bit counter.
REQ-022 Auto-repeat transitions:
- IDLE->DELAY on a left or right press event.
- DELAY->REPEAT after DAS_CYCLES of continuous hold, emitting an event.
- REPEAT emits an event every ARR_CYCLES.
- Any state returns to IDLE on release of the tracked direction, or when both directions are held.
REQ-023 Fall SHALL never auto-repeat.
REQ-024 Auto-repeat events SHALL obey REQ-015 to REQ-017 identically to press events.

Reset
REQ-025 Assertion of rst SHALL immediately clear the following:
- cmd_valid=0, cmd=2'b00 and cmd_drop=0;
- synchronizers, debounced levels, registered levels, counters;
- FSM to IDLE.
REQ-026 A key held through deassertion of rst SHALL NOT generate an event until it is released and pressed again.
REQ-027 cmd_drop SHALL clear only on reset.

Configuration
REQ-028 With MOVE_CMD_AUTOREPEAT_EN defined, REQ-021 to REQ-024 SHALL be implemented.
REQ-029 Without MOVE_CMD_AUTOREPEAT_EN, the FSM and its counter SHALL be absent, and only press events generate commands.

Structure
REQ-030 Shared package move_cmd_pkg SHALL hold:
- command code constants CMD_NONE, CMD_LEFT, CMD_RIGHT and CMD_FALL;
- FSM state encodings.
REQ-031 The synchronizer plus debouncer SHALL be sub-module btn_debounce, instantiated three times.

Verification
REQ-032 Bench SHALL cover the following directed scenarios, with DEB_CYCLES=4, DAS_CYCLES=20, ARR_CYCLES=5:
- key_left high at edge 10, cmd_ack held 0 -> cmd=01 and cmd_valid=1 after edge 12, held; cmd_drop=0.
- btn_r bouncing 1/0 for 3 cycles then steady high -> exactly one cmd=10, 2+4+2 cycles after the steady start.
- key_fall and key_left rise on the same edge -> cmd=11, cmd_drop=1; after ack, cmd_valid=0 and no left command.
- key_right held 40 cycles with cmd_ack tied 1 (auto-repeat built in) -> right commands at press, +20, +25, +30, +35; without MOVE_CMD_AUTOREPEAT_EN, press only.
- Left held in REPEAT, then right pressed -> FSM to IDLE, one right press command, no further repeats.
- rst pulsed low mid-DELAY with cmd_valid=1 -> outputs cleared asynchronously; no command until key released and re-pressed.

Source files
------------

// File: rtl/move_cmd_pkg.sv
// Shared command codes and auto-repeat state encoding for move_cmd_gen.
package move_cmd_pkg;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_LEFT  = 2'b01;
  localparam logic [1:0] CMD_RIGHT = 2'b10;
  localparam logic [1:0] CMD_FALL  = 2'b11;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StDelay  = 2'b01,
    StRepeat = 2'b10
  } rpt_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counter debouncer; the output level
// follows the input only after DEB_CYCLES consecutive differing samples.
module btn_debounce #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o
);

  logic        sync1_q, sync2_q, level_q;
  logic [15:0] cnt_q;
  logic        cnt_done;

  // Widened compare keeps DEB_CYCLES of 0 or 1 meaning "accept immediately".
  assign cnt_done = ({1'b0, cnt_q} + 17'd1) >= {1'b0, DEB_CYCLES};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_done) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/move_cmd_gen.sv
// Merges debounced buttons and keyboard levels into a one-entry move command buffer.
// Auto-repeat of left/right is built only when MOVE_CMD_AUTOREPEAT_EN is defined.
module move_cmd_gen
  import move_cmd_pkg::*;
#(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter logic [23:0] DAS_CYCLES = 24'd10000000,
  parameter logic [23:0] ARR_CYCLES = 24'd2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_c,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_fall,
  output logic       cmd_valid,
  output logic [1:0] cmd,
  input  logic       cmd_ack,
  output logic       cmd_drop
);

  // Per-direction vectors are ordered {fall, right, left}.
  logic [2:0] deb_lvl, lvl_d, lvl_q, prev_q, arm_q, press_q;
  logic [1:0] rpt_evt;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
    .clk_i(clk), .rst_ni(rst), .btn_i(btn_l), .level_o(deb_lvl[0])
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
    .clk_i(clk), .rst_ni(rst), .btn_i(btn_r), .level_o(deb_lvl[1])
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_c (
    .clk_i(clk), .rst_ni(rst), .btn_i(btn_c), .level_o(deb_lvl[2])
  );

  assign lvl_d = deb_lvl | {key_fall, key_right, key_left};

  // arm_q stays low until a direction is seen released, so a level held
  // through reset never looks like a fresh press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_q   <= '0;
      prev_q  <= '0;
      arm_q   <= '0;
      press_q <= '0;
    end else begin
      lvl_q   <= lvl_d;
      prev_q  <= lvl_q;
      arm_q   <= arm_q | ~lvl_d;
      press_q <= lvl_q & ~prev_q & arm_q;
    end
  end

`ifdef MOVE_CMD_AUTOREPEAT_EN
  rpt_state_e  state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        dir_q, dir_d;  // 0 = left, 1 = right
  logic        held, both, das_done, arr_done;

  always_comb begin
    both     = lvl_q[0] & lvl_q[1];
    held     = dir_q ? lvl_q[1] : lvl_q[0];
    das_done = ({1'b0, cnt_q} + 25'd1) >= {1'b0, DAS_CYCLES};
    arr_done = ({1'b0, cnt_q} + 25'd1) >= {1'b0, ARR_CYCLES};
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    rpt_evt  = '0;
    unique case (state_q)
      StIdle: begin
        if ((press_q[0] | press_q[1]) && !both) begin
          state_d = StDelay;
          cnt_d   = '0;
          dir_d   = ~press_q[0];
        end
      end
      StDelay: begin
        if (!held || both) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (das_done) begin
          state_d          = StRepeat;
          cnt_d            = '0;
          rpt_evt[dir_q]   = 1'b1;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      StRepeat: begin
        if (!held || both) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (arr_done) begin
          cnt_d          = '0;
          rpt_evt[dir_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end
`else
  assign rpt_evt = '0;
  logic unused_params;
  assign unused_params = ^{DAS_CYCLES, ARR_CYCLES};
`endif

  logic [2:0] evt;
  logic       load_ok, multi, valid_q, valid_d, drop_q, drop_d;
  logic [1:0] sel, cmd_q, cmd_d;

  always_comb begin
    evt     = {press_q[2], press_q[1] | rpt_evt[1], press_q[0] | rpt_evt[0]};
    load_ok = ~valid_q | cmd_ack;
    multi   = (evt[0] & evt[1]) | (evt[0] & evt[2]) | (evt[1] & evt[2]);
    sel     = CMD_NONE;
    if (evt[2])      sel = CMD_FALL;
    else if (evt[0]) sel = CMD_LEFT;
    else if (evt[1]) sel = CMD_RIGHT;
    valid_d = valid_q;
    cmd_d   = cmd_q;
    drop_d  = drop_q | multi | ((|evt) & ~load_ok);
    if ((|evt) && load_ok) begin
      valid_d = 1'b1;
      cmd_d   = sel;
    end else if (valid_q && cmd_ack) begin
      valid_d = 1'b0;
      cmd_d   = CMD_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      cmd_q   <= CMD_NONE;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      drop_q  <= drop_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd       = cmd_q;
  assign cmd_drop  = drop_q;

endmodule

// File: tb/tb_move_cmd_gen.sv
// Self-checking bench for move_cmd_gen: vector table, directed corner sequences and
// a randomized run against a behavioural model. Honors MOVE_CMD_AUTOREPEAT_EN.
module tb_move_cmd_gen;
  import move_cmd_pkg::*;

  localparam int DAS = 20;
  localparam int ARR = 5;
`ifdef MOVE_CMD_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_l = 1'b0, btn_r = 1'b0, btn_c = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, key_fall = 1'b0;
  logic       cmd_ack = 1'b0;
  logic       cmd_valid, cmd_drop;
  logic [1:0] cmd;

  move_cmd_gen #(
    .DEB_CYCLES(16'd4),
    .DAS_CYCLES(24'd20),
    .ARR_CYCLES(24'd5)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_l(btn_l), .btn_r(btn_r), .btn_c(btn_c),
    .key_left(key_left), .key_right(key_right), .key_fall(key_fall),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ack(cmd_ack), .cmd_drop(cmd_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    {key_fall, key_right, key_left} = 3'b000;
    {btn_l, btn_r, btn_c} = 3'b000;
    cmd_ack = 1'b0;
    rst = 1'b0;
    #1;
    check("reset_valid", cmd_valid, 0);
    check("reset_cmd", cmd, 0);
    check("reset_drop", cmd_drop, 0);
    tick_n(2);
    rst = 1'b1;
  endtask

  // Behavioural model: samples[d][j] = key level sampled j edges ago.
  int       m_ne;
  bit       samples[3][4];
  bit       m_trk, m_dir;
  int       m_start;
  bit       m_valid, m_drop;
  bit [1:0] m_cmd;

  function automatic void model_reset();
    m_ne = 0;
    for (int d = 0; d < 3; d++) for (int j = 0; j < 4; j++) samples[d][j] = 1'b0;
    m_trk = 1'b0; m_dir = 1'b0; m_start = 0;
    m_valid = 1'b0; m_drop = 1'b0; m_cmd = 2'b00;
  endfunction

  function automatic void model_edge(input bit [2:0] k, input bit ack);
    bit [2:0] press, ev;
    bit [1:0] rpt;
    bit       both_prev, held, loadable;
    int       n, age;
    m_ne++;
    for (int d = 0; d < 3; d++) begin
      for (int j = 3; j > 0; j--) samples[d][j] = samples[d][j-1];
      samples[d][0] = k[d];
    end
    both_prev = (m_ne >= 2) && samples[0][1] && samples[1][1];
    // A sampled 0->1 becomes a command candidate two edges later.
    for (int d = 0; d < 3; d++) press[d] = (m_ne >= 4) && samples[d][2] && !samples[d][3];
    rpt = 2'b00;
    if (AR) begin
      if (m_trk) begin
        held = (m_ne >= 2) && samples[m_dir][1];
        if (!held || both_prev) begin
          m_trk = 1'b0;
        end else begin
          age = m_ne - m_start;
          if (age == DAS || (age > DAS && (age - DAS) % ARR == 0)) rpt[m_dir] = 1'b1;
        end
      end else if ((press[0] || press[1]) && !both_prev) begin
        m_trk = 1'b1;
        m_start = m_ne;
        m_dir = press[0] ? 1'b0 : 1'b1;
      end
    end
    ev = press | {1'b0, rpt};
    n = int'(ev[0]) + int'(ev[1]) + int'(ev[2]);
    loadable = !m_valid || ack;
    if (n > 1 || (n > 0 && !loadable)) m_drop = 1'b1;
    if (n > 0 && loadable) begin
      m_valid = 1'b1;
      m_cmd = ev[2] ? 2'b11 : (ev[0] ? 2'b01 : 2'b10);
    end else if (m_valid && ack) begin
      m_valid = 1'b0;
      m_cmd = 2'b00;
    end
  endfunction

  typedef struct {
    bit [2:0] keys;  // {fall, right, left}
    bit       exp_valid;
    bit [1:0] exp_cmd;
    bit       exp_drop;
  } vec_t;

  initial begin
    vec_t     tbl[8];
    bit       got4[60];
    int       exp4[$];
    bit [1:0] exp5[80], act5[80];
    int       cnt, bad;

    tbl[0] = '{3'b001, 1'b1, CMD_LEFT,  1'b0};
    tbl[1] = '{3'b010, 1'b1, CMD_RIGHT, 1'b0};
    tbl[2] = '{3'b100, 1'b1, CMD_FALL,  1'b0};
    tbl[3] = '{3'b011, 1'b1, CMD_LEFT,  1'b1};
    tbl[4] = '{3'b110, 1'b1, CMD_FALL,  1'b1};
    tbl[5] = '{3'b101, 1'b1, CMD_FALL,  1'b1};
    tbl[6] = '{3'b111, 1'b1, CMD_FALL,  1'b1};
    tbl[7] = '{3'b000, 1'b0, CMD_NONE,  1'b0};

    #2;
    for (int i = 0; i < 8; i++) begin
      do_reset();
      tick_n(2);
      {key_fall, key_right, key_left} = tbl[i].keys;
      tick_n(3);
      check($sformatf("tbl%0d_valid", i), cmd_valid, tbl[i].exp_valid);
      check($sformatf("tbl%0d_cmd", i), cmd, tbl[i].exp_cmd);
      check($sformatf("tbl%0d_drop", i), cmd_drop, tbl[i].exp_drop);
      {key_fall, key_right, key_left} = 3'b000;
      cmd_ack = 1'b1;
      tick();
      cmd_ack = 1'b0;
      check($sformatf("tbl%0d_ack_valid", i), cmd_valid, 0);
      check($sformatf("tbl%0d_ack_cmd", i), cmd, 0);
      check($sformatf("tbl%0d_ack_drop", i), cmd_drop, tbl[i].exp_drop);
    end

    // Key latency: sampled at edge 10, valid after edge 12.
    do_reset();
    tick_n(9);
    key_left = 1'b1;
    tick_n(2);
    check("s1_valid_e11", cmd_valid, 0);
    tick();
    check("s1_valid_e12", cmd_valid, 1);
    check("s1_cmd_e12", cmd, CMD_LEFT);
    tick_n(5);
    check("s1_valid_held", cmd_valid, 1);
    check("s1_cmd_held", cmd, CMD_LEFT);
    check("s1_drop", cmd_drop, 0);

    // Bouncing button then steady: one command 8 edges after steady start.
    do_reset();
    tick_n(2);
    for (int i = 0; i < 3; i++) begin
      btn_r = 1'b1; tick();
      btn_r = 1'b0; tick();
    end
    btn_r = 1'b1;
    tick();
    tick_n(7);
    check("s2_valid_s7", cmd_valid, 0);
    tick();
    check("s2_valid_s8", cmd_valid, 1);
    check("s2_cmd_s8", cmd, CMD_RIGHT);
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cmd_valid) cnt++;
    end
    check("s2_no_second", cnt, 0);
    check("s2_drop", cmd_drop, 0);
    btn_r = 1'b0;
    tick_n(10);

    // Simultaneous fall + left.
    do_reset();
    tick_n(2);
    key_fall = 1'b1; key_left = 1'b1;
    tick_n(3);
    check("s3_cmd", cmd, CMD_FALL);
    check("s3_valid", cmd_valid, 1);
    check("s3_drop", cmd_drop, 1);
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    check("s3_ack_valid", cmd_valid, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cmd_valid) cnt++;
    end
    check("s3_no_left", cnt, 0);
    key_fall = 1'b0; key_left = 1'b0;
    tick_n(10);

    // Right held 40 edges with ack tied high.
    do_reset();
    tick_n(2);
    cmd_ack = 1'b1;
    key_right = 1'b1;
    cnt = 0; bad = 0;
    for (int t = 0; t < 60; t++) begin
      if (t == 40) key_right = 1'b0;
      tick();
      got4[t] = cmd_valid;
      if (cmd_valid) begin
        cnt++;
        if (cmd != CMD_RIGHT) bad++;
      end
    end
    cmd_ack = 1'b0;
    if (AR) exp4 = '{2, 22, 27, 32, 37};
    else    exp4 = '{2};
    check("s4_count", cnt, exp4.size());
    check("s4_cmd_code_errs", bad, 0);
    foreach (exp4[i]) check($sformatf("s4_cmd_at_%0d", exp4[i]), got4[exp4[i]], 1);

    // Left repeating, then right pressed: one right press, repeats stop.
    do_reset();
    tick_n(2);
    cmd_ack = 1'b1;
    key_left = 1'b1;
    for (int t = 0; t < 80; t++) exp5[t] = CMD_NONE;
    exp5[2] = CMD_LEFT;
    if (AR) begin
      exp5[22] = CMD_LEFT;
      exp5[27] = CMD_LEFT;
    end
    exp5[31] = CMD_RIGHT;
    for (int t = 0; t < 80; t++) begin
      if (t == 29) key_right = 1'b1;
      if (t == 60) key_right = 1'b0;
      tick();
      act5[t] = cmd_valid ? cmd : CMD_NONE;
    end
    bad = 0;
    for (int t = 0; t < 80; t++) if (act5[t] != exp5[t]) bad++;
    check("s5_sequence_errs", bad, 0);
    check("s5_right_at_31", act5[31], CMD_RIGHT);
    cmd_ack = 1'b0;
    key_left = 1'b0;
    tick_n(5);

    // Asynchronous reset mid-DELAY with a buffered command and drop set.
    do_reset();
    tick_n(2);
    key_left = 1'b1;
    tick_n(3);
    check("s6_pre_valid", cmd_valid, 1);
    key_fall = 1'b1;
    tick_n(4);
    check("s6_pre_drop", cmd_drop, 1);
    check("s6_pre_cmd", cmd, CMD_LEFT);
    #3;
    rst = 1'b0;
    #1;
    check("s6_async_valid", cmd_valid, 0);
    check("s6_async_cmd", cmd, 0);
    check("s6_async_drop", cmd_drop, 0);
    tick_n(2);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cmd_valid) cnt++;
    end
    check("s6_no_cmd_held", cnt, 0);
    key_left = 1'b0; key_fall = 1'b0;
    tick_n(3);
    key_left = 1'b1;
    tick_n(3);
    check("s6_repress_valid", cmd_valid, 1);
    check("s6_repress_cmd", cmd, CMD_LEFT);
    key_left = 1'b0;
    tick_n(5);

    // Randomized keys and ack against the model.
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i > 0 && i % 1000 == 0) begin
        do_reset();
        model_reset();
      end
      if ($urandom_range(19) == 0) key_left = ~key_left;
      if ($urandom_range(19) == 0) key_right = ~key_right;
      if ($urandom_range(9) == 0) key_fall = ~key_fall;
      cmd_ack = 1'($urandom_range(1));
      @(posedge clk);
      model_edge({key_fall, key_right, key_left}, cmd_ack);
      #1;
      check("rnd_valid", cmd_valid, m_valid);
      check("rnd_cmd", cmd, m_cmd);
      check("rnd_drop", cmd_drop, m_drop);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
